// File: rtl/cue_ball_motion_if.sv
// Shot-velocity input and ball-position output bundle for the cue-ball motion stage.
// master: direction-line stage / frame timing / drawers; slave: the motion block.
// Pure wiring, no storage.
interface cue_ball_motion_if;
  logic               startOfFrame;
  logic signed [10:0] newVelocityX;
  logic signed [10:0] newVelocityY;
  logic               velocityWriteEnable;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               ballMoving;
  logic               lineEnable;
  logic               shotDone;

  modport master (
    output startOfFrame, newVelocityX, newVelocityY, velocityWriteEnable,
    input  topLeftX, topLeftY, ballMoving, lineEnable, shotDone
  );

  modport slave (
    input  startOfFrame, newVelocityX, newVelocityY, velocityWriteEnable,
    output topLeftX, topLeftY, ballMoving, lineEnable, shotDone
  );
endinterface

// File: rtl/cue_ball_motion.sv
// Fixed-point cue-ball integrator: wall bounces per axis, friction every FRICTION_PERIOD frames.
// Shot accepted one clk after the write; position updates one clk after each startOfFrame.
// No backpressure: writes are ignored while moving, startOfFrame is ignored while idle.
module cue_ball_motion #(
  parameter int FRAC_BITS       = 6,
  parameter int VELOCITY_LIMIT  = 200,
  parameter int INITIAL_X       = 300,
  parameter int INITIAL_Y       = 200,
  parameter int LEFT_BOUND      = 40,
  parameter int RIGHT_BOUND     = 580,
  parameter int TOP_BOUND       = 40,
  parameter int BOTTOM_BOUND    = 420,
  parameter int FRICTION_PERIOD = 4,
  parameter int FRICTION_STEP   = 1
) (
  input logic            clk,
  input logic            resetN,
  cue_ball_motion_if.slave bus
);

  localparam int POS_W = 18;
  localparam int VEL_W = 11;
  localparam int CNT_W = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    MOVING = 1'b1
  } state_t;

  typedef struct packed {
    logic signed [POS_W-1:0] pos;
    logic signed [VEL_W-1:0] vel;
  } axis_t;

  localparam logic signed [VEL_W-1:0] VEL_LIM    = VEL_W'(VELOCITY_LIMIT);
  localparam logic signed [VEL_W-1:0] FRIC       = VEL_W'(FRICTION_STEP);
  localparam logic signed [POS_W-1:0] INIT_X_FIX = POS_W'(INITIAL_X << FRAC_BITS);
  localparam logic signed [POS_W-1:0] INIT_Y_FIX = POS_W'(INITIAL_Y << FRAC_BITS);
  localparam logic signed [POS_W-1:0] LEFT_I     = POS_W'(LEFT_BOUND);
  localparam logic signed [POS_W-1:0] RIGHT_I    = POS_W'(RIGHT_BOUND);
  localparam logic signed [POS_W-1:0] TOP_I      = POS_W'(TOP_BOUND);
  localparam logic signed [POS_W-1:0] BOTTOM_I   = POS_W'(BOTTOM_BOUND);
  localparam logic [CNT_W-1:0]        CNT_LAST   = CNT_W'(FRICTION_PERIOD - 1);

  state_t                  state;
  logic signed [POS_W-1:0] pos_x, pos_y;
  logic signed [VEL_W-1:0] vel_x, vel_y;
  logic [CNT_W-1:0]        frame_cnt;

  axis_t                   bx, by;
  logic signed [VEL_W-1:0] clamp_x, clamp_y;
  logic signed [VEL_W-1:0] fric_x, fric_y;
  logic                    fric_event;
  logic                    shot_nonzero;

  function automatic logic signed [VEL_W-1:0] clamp_vel(input logic signed [VEL_W-1:0] v);
    logic signed [VEL_W-1:0] r;
    r = v;
    if (v > VEL_LIM)
      r = VEL_LIM;
    else if (v < -VEL_LIM)
      r = -VEL_LIM;
    return r;
  endfunction

  function automatic logic signed [VEL_W-1:0] abs_vel(input logic signed [VEL_W-1:0] v);
    return v[VEL_W-1] ? -v : v;
  endfunction

  // Magnitude shrinks toward zero and never crosses sign.
  function automatic logic signed [VEL_W-1:0] apply_friction(input logic signed [VEL_W-1:0] v);
    logic signed [VEL_W-1:0] r;
    if (abs_vel(v) <= FRIC)
      r = '0;
    else if (v[VEL_W-1])
      r = v + FRIC;
    else
      r = v - FRIC;
    return r;
  endfunction

  // Move one frame, then pin to the wall and point the velocity back inside on a hit.
  function automatic axis_t bounce(input logic signed [POS_W-1:0] pos,
                                   input logic signed [VEL_W-1:0] vel,
                                   input logic signed [POS_W-1:0] lo,
                                   input logic signed [POS_W-1:0] hi);
    logic signed [POS_W-1:0] nxt;
    logic signed [POS_W-1:0] nxt_int;
    axis_t                   r;
    nxt     = pos + $signed({{(POS_W-VEL_W){vel[VEL_W-1]}}, vel});
    nxt_int = nxt >>> FRAC_BITS;
    r.pos   = nxt;
    r.vel   = vel;
    if (nxt_int < lo) begin
      r.pos = lo <<< FRAC_BITS;
      r.vel = abs_vel(vel);
    end else if (nxt_int > hi) begin
      r.pos = hi <<< FRAC_BITS;
      r.vel = -abs_vel(vel);
    end
    return r;
  endfunction

  // Next-frame candidates: clamped shot, bounced position, friction-adjusted velocity.
  always_comb begin
    clamp_x      = clamp_vel(bus.newVelocityX);
    clamp_y      = clamp_vel(bus.newVelocityY);
    shot_nonzero = (clamp_x != '0) || (clamp_y != '0);
    bx           = bounce(pos_x, vel_x, LEFT_I, RIGHT_I);
    by           = bounce(pos_y, vel_y, TOP_I, BOTTOM_I);
    fric_event   = (frame_cnt == CNT_LAST);
    fric_x       = fric_event ? apply_friction(bx.vel) : bx.vel;
    fric_y       = fric_event ? apply_friction(by.vel) : by.vel;
  end

  // Shot FSM with registered position, velocity and status outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state          <= IDLE;
      pos_x          <= INIT_X_FIX;
      pos_y          <= INIT_Y_FIX;
      vel_x          <= '0;
      vel_y          <= '0;
      frame_cnt      <= '0;
      bus.topLeftX   <= VEL_W'(INITIAL_X);
      bus.topLeftY   <= VEL_W'(INITIAL_Y);
      bus.ballMoving <= 1'b0;
      bus.lineEnable <= 1'b1;
      bus.shotDone   <= 1'b0;
    end else begin
      bus.shotDone <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.velocityWriteEnable && shot_nonzero) begin
            vel_x          <= clamp_x;
            vel_y          <= clamp_y;
            frame_cnt      <= '0;
            state          <= MOVING;
            bus.ballMoving <= 1'b1;
            bus.lineEnable <= 1'b0;
          end
        end
        MOVING: begin
          if (bus.startOfFrame) begin
            pos_x        <= bx.pos;
            pos_y        <= by.pos;
            bus.topLeftX <= bx.pos[FRAC_BITS +: VEL_W];
            bus.topLeftY <= by.pos[FRAC_BITS +: VEL_W];
            vel_x        <= fric_x;
            vel_y        <= fric_y;
            frame_cnt    <= fric_event ? '0 : frame_cnt + CNT_W'(1);
            if (fric_x == '0 && fric_y == '0) begin
              state          <= IDLE;
              bus.ballMoving <= 1'b0;
              bus.lineEnable <= 1'b1;
              bus.shotDone   <= 1'b1;
            end
          end
        end
        default: begin
          state          <= IDLE;
          bus.ballMoving <= 1'b0;
          bus.lineEnable <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cue_ball_motion.sv
// Self-checking bench for cue_ball_motion: constant vector table, corner sequences,
// and a randomized run compared every clk against an integer-arithmetic ball model.
module tb_cue_ball_motion;

  localparam int FP = 64;  // fixed-point scale, 1 px = 64 units

  logic clk = 1'b0;
  logic resetN;
  cue_ball_motion_if bus ();

  cue_ball_motion dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference ball state (plain integers, fixed-point position in 1/64 px).
  int m_px, m_py, m_vx, m_vy, m_frames;
  bit m_moving, m_done;

  typedef struct {
    bit sof;
    bit we;
    int vx;
    int vy;
    int ex;
    int ey;
    bit emov;
    bit edone;
  } vec_t;

  vec_t tbl[10];

  function automatic int clampv(input int v);
    if (v > 200) return 200;
    if (v < -200) return -200;
    return v;
  endfunction

  function automatic int slow(input int v);
    int mag;
    mag = (v < 0) ? -v : v;
    mag = (mag > 1) ? mag - 1 : 0;
    return (v < 0) ? -mag : mag;
  endfunction

  task automatic axis_step(inout int p, inout int v, input int lo, input int hi);
    int nx;
    nx = p + v;
    if (nx / FP < lo) begin
      p = lo * FP;
      v = (v < 0) ? -v : v;
    end else if (nx / FP > hi) begin
      p = hi * FP;
      v = (v > 0) ? -v : v;
    end else begin
      p = nx;
    end
  endtask

  task automatic model_reset();
    m_px = 300 * FP; m_py = 200 * FP;
    m_vx = 0; m_vy = 0; m_frames = 0;
    m_moving = 0; m_done = 0;
  endtask

  task automatic model_step(input bit sof, input bit we, input int vx, input int vy);
    m_done = 0;
    if (!m_moving) begin
      if (we && (clampv(vx) != 0 || clampv(vy) != 0)) begin
        m_vx = clampv(vx); m_vy = clampv(vy);
        m_frames = 0; m_moving = 1;
      end
    end else if (sof) begin
      axis_step(m_px, m_vx, 40, 580);
      axis_step(m_py, m_vy, 40, 420);
      m_frames++;
      if (m_frames == 4) begin
        m_frames = 0;
        m_vx = slow(m_vx);
        m_vy = slow(m_vy);
      end
      if (m_vx == 0 && m_vy == 0) begin
        m_moving = 0;
        m_done = 1;
      end
    end
  endtask

  task automatic check_out(input string name, input int ex, input int ey, input bit emov, input bit edone);
    n_cmp++;
    if ($signed(bus.topLeftX) !== ex || $signed(bus.topLeftY) !== ey || bus.ballMoving !== emov ||
        bus.lineEnable !== !emov || bus.shotDone !== edone) begin
      n_bad++;
      $display("FAIL %s t=%0t: got x=%0d y=%0d mov=%b line=%b done=%b, want x=%0d y=%0d mov=%b line=%b done=%b",
               name, $time, $signed(bus.topLeftX), $signed(bus.topLeftY), bus.ballMoving, bus.lineEnable,
               bus.shotDone, ex, ey, emov, !emov, edone);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // One clk: drive at negedge, advance the model, sample 1 time unit after posedge.
  task automatic cycle(input bit sof, input bit we, input int vx, input int vy);
    @(negedge clk);
    bus.startOfFrame        = sof;
    bus.velocityWriteEnable = we;
    bus.newVelocityX        = 11'(vx);
    bus.newVelocityY        = 11'(vy);
    model_step(sof, we, vx, vy);
    @(posedge clk);
    #1;
    check_out("model", m_px / FP, m_py / FP, m_moving, m_done);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must return immediately.
  task automatic do_reset();
    @(negedge clk);
    #2;
    resetN                  = 1'b0;
    bus.startOfFrame        = 1'b0;
    bus.velocityWriteEnable = 1'b0;
    bus.newVelocityX        = '0;
    bus.newVelocityY        = '0;
    model_reset();
    #1;
    check_out("reset", 300, 200, 1'b0, 1'b0);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x, y, viol, pvx, pvy;
    bit xhit, yhit, xaway, yaway, xpend, ypend;

    // vx = 64 shot: 1 px per frame, friction after the 4th frame leaves 63/64 px per frame.
    tbl[0] = '{1'b0, 1'b1,   64, 0, 300, 200, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0,    0, 0, 301, 200, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0,    0, 0, 301, 200, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0,    0, 0, 302, 200, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0,    0, 0, 303, 200, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0,    0, 0, 304, 200, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b0,    0, 0, 304, 200, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0,    0, 0, 305, 200, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b1, -200, 0, 305, 200, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 1'b0,    0, 0, 306, 200, 1'b1, 1'b0};

    resetN                  = 1'b0;
    bus.startOfFrame        = 1'b0;
    bus.velocityWriteEnable = 1'b0;
    bus.newVelocityX        = '0;
    bus.newVelocityY        = '0;
    model_reset();
    do_reset();

    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].sof, tbl[i].we, tbl[i].vx, tbl[i].vy);
      check_out("table", tbl[i].ex, tbl[i].ey, tbl[i].emov, tbl[i].edone);
    end

    // Slowest shot: stops on the 4th frame at 19204 units, one-clk shotDone.
    do_reset();
    cycle(1'b0, 1'b1, 1, 0);
    for (int f = 0; f < 3; f++) cycle(1'b1, 1'b0, 0, 0);
    cycle(1'b1, 1'b0, 0, 0);
    check_out("stop_frame", 300, 200, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 0, 0);
    check_out("done_one_clk", 300, 200, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 0, 0);
    check_out("idle_ignores_sof", 300, 200, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 60, 0);
    cycle(1'b1, 1'b0, 0, 0);
    check_out("kept_fraction", 301, 200, 1'b1, 1'b0);

    // Zero write leaves the ball idle with no completion pulse.
    do_reset();
    cycle(1'b0, 1'b1, 0, 0);
    check_out("zero_write", 300, 200, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 0, 0);
    check_out("zero_write_frame", 300, 200, 1'b0, 1'b0);

    // Write coinciding with startOfFrame: write wins, movement starts on the next frame.
    do_reset();
    cycle(1'b1, 1'b1, 64, 0);
    check_out("write_wins", 300, 200, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 0, 0);
    check_out("first_move", 301, 200, 1'b1, 1'b0);

    // Reset mid-motion, then a normal shot.
    do_reset();
    cycle(1'b0, 1'b1, 150, 0);
    for (int f = 0; f < 5; f++) cycle(1'b1, 1'b0, 0, 0);
    check_val("moved_before_reset", $signed(bus.topLeftX), 311);
    do_reset();
    cycle(1'b0, 1'b1, 64, 0);
    cycle(1'b1, 1'b0, 0, 0);
    check_out("post_reset_shot", 301, 200, 1'b1, 1'b0);

    // Clamped diagonal shot run into the right and top walls until it stops.
    do_reset();
    cycle(1'b0, 1'b1, 500, -500);
    cycle(1'b1, 1'b0, 0, 0);
    check_val("clamp_x", $signed(bus.topLeftX), 303);
    check_val("clamp_y", $signed(bus.topLeftY), 196);
    viol = 0; xhit = 0; yhit = 0; xaway = 0; yaway = 0; xpend = 0; ypend = 0;
    for (int f = 0; f < 1000 && m_moving; f++) begin
      pvx = m_vx; pvy = m_vy;
      cycle(1'b0, 1'b0, 0, 0);
      cycle(1'b1, 1'b0, 0, 0);
      x = $signed(bus.topLeftX);
      y = $signed(bus.topLeftY);
      if (x < 40 || x > 580 || y < 40 || y > 420) viol++;
      if (xpend) begin check_val("x_moves_away", int'(x < 580), 1); xpend = 0; xaway = 1; end
      if (ypend) begin check_val("y_moves_away", int'(y > 40), 1); ypend = 0; yaway = 1; end
      if (!xhit && pvx > 0 && m_vx < 0) begin
        xhit = 1; xpend = 1;
        check_val("x_hit_at_bound", x, 580);
      end
      if (!yhit && pvy < 0 && m_vy > 0) begin
        yhit = 1; ypend = 1;
        check_val("y_hit_at_bound", y, 40);
      end
    end
    check_val("bounds_violations", viol, 0);
    check_val("x_wall_hit_seen", int'(xhit & xaway), 1);
    check_val("y_wall_hit_seen", int'(yhit & yaway), 1);
    check_val("corner_shot_stopped", int'(bus.ballMoving), 0);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      bit sof, we;
      int vx, vy;
      sof = ($urandom_range(0, 2) == 0);
      we  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) begin
        vx = int'($urandom_range(0, 1200)) - 600;
        vy = int'($urandom_range(0, 1200)) - 600;
      end else begin
        vx = int'($urandom_range(0, 80)) - 40;
        vy = int'($urandom_range(0, 80)) - 40;
      end
      cycle(sof, we, vx, vy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
